mcu_serial_rx: RTL

- UART receiver, 8N1, LSB first, for the MCU/AVR serial link into the FPGA. It is the receive counterpart of the existing tx path.
- It deserialises the asynchronous `rx` pin into bytes with a one-cycle strobe, which feeds the config/command decoder (`rx_data`/`new_rx_data` consumers).
- It detects framing errors and line breaks, and recovers cleanly to idle.
- It runs in the `sys_clock` domain.

---
 rtl/mcu_serial_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mcu_serial_rx.sv
// 8N1 UART receiver, LSB first, for the MCU serial link in the sys_clock domain.
// Emits one-cycle strobes for a good byte, a framing error, and a line break.
module mcu_serial_rx #(
  parameter  int CLKS_PER_BIT = 100,
  localparam int CTR_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_data,
  output logic       frame_err,
  output logic       brk,
  output logic       busy
);

  localparam int               H        = CLKS_PER_BIT / 2;
  localparam logic [CTR_W-1:0] CTR_ZERO = CTR_W'(0);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(H - 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CTR_W-1:0] ctr_r, ctr_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       rx_data_r, rx_data_s;
  logic             new_data_r, new_data_s;
  logic             frame_err_r, frame_err_s;
  logic             brk_r, brk_s;
  logic             busy_r, busy_s;
  logic             rx_meta_r, rx_sync_r;

  // A break is a frame whose data bits all read low.
  function automatic logic is_break(input logic [7:0] bits);
    return (bits == 8'h00);
  endfunction

  // Two-flop synchronizer on the asynchronous line; both stages rest at idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, datapath and strobe decode; strobes fall back to 0 each cycle.
  always_comb begin
    state_s     = state_r;
    ctr_s       = ctr_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    rx_data_s   = rx_data_r;
    new_data_s  = 1'b0;
    frame_err_s = 1'b0;
    brk_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        ctr_s = CTR_ZERO;
        if (!rx_sync_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      // Re-check the line half a bit in so a short glitch is not taken as a start.
      ST_START: begin
        if (ctr_r == CTR_HALF) begin
          ctr_s = CTR_ZERO;
          if (!rx_sync_r) begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          ctr_s = ctr_r + CTR_ONE;
        end
      end

      ST_DATA: begin
        if (ctr_r == CTR_LAST) begin
          ctr_s   = CTR_ZERO;
          shift_s = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          ctr_s = ctr_r + CTR_ONE;
        end
      end

      // Leaving mid stop bit keeps the next start edge within reach.
      ST_STOP: begin
        if (ctr_r == CTR_LAST) begin
          ctr_s = CTR_ZERO;
          if (rx_sync_r) begin
            rx_data_s  = shift_r;
            new_data_s = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            brk_s       = is_break(shift_r);
            state_s     = ST_WAIT_HIGH;
          end
        end else begin
          ctr_s = ctr_r + CTR_ONE;
        end
      end

      ST_WAIT_HIGH: begin
        ctr_s = CTR_ZERO;
        if (rx_sync_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        ctr_s     = CTR_ZERO;
        bit_idx_s = 3'd0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ctr_r       <= CTR_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      new_data_r  <= 1'b0;
      frame_err_r <= 1'b0;
      brk_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ctr_r       <= ctr_s;
      bit_idx_r   <= bit_idx_s;
      shift_r     <= shift_s;
      rx_data_r   <= rx_data_s;
      new_data_r  <= new_data_s;
      frame_err_r <= frame_err_s;
      brk_r       <= brk_s;
      busy_r      <= busy_s;
    end
  end

  assign rx_data   = rx_data_r;
  assign new_data  = new_data_r;
  assign frame_err = frame_err_r;
  assign brk       = brk_r;
  assign busy      = busy_r;

endmodule
